// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, idx 0..10.
// Define AES_KEY_STORE_EN to add an 11-entry round-key store with a read port.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    s = b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  end

endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         ready,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [7:0]  rcon;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign rk  = {w0, w1, w2, w3};
  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sb0 (.a(rot[31:24]), .s(sub[31:24]));
  aes_sbox u_sb1 (.a(rot[23:16]), .s(sub[23:16]));
  aes_sbox u_sb2 (.a(rot[15:8]),  .s(sub[15:8]));
  aes_sbox u_sb3 (.a(rot[7:0]),   .s(sub[7:0]));

  always_comb begin
    temp = sub ^ {rcon, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
  end

  // rk_idx doubles as the round counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      done     <= 1'b0;
      rcon     <= 8'h01;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= EXPAND;
            ready    <= 1'b0;
            rk_valid <= 1'b1;
            rk_idx   <= '0;
            rcon     <= 8'h01;
            {w0, w1, w2, w3} <= key;
          end
        end
        EXPAND: begin
          if (rk_idx < 4'd10) begin
            w0     <= n0;
            w1     <= n1;
            w2     <= n2;
            w3     <= n3;
            rk_idx <= rk_idx + 4'd1;
            done   <= (rk_idx == 4'd9);
            rcon   <= rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b)
                              : {rcon[6:0], 1'b0};
          end else begin
            state    <= IDLE;
            ready    <= 1'b1;
            rk_valid <= 1'b0;
            done     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] mem [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) mem[i] <= '0;
    end else if (rk_valid && rk_idx <= 4'd10) begin
      mem[rk_idx] <= rk;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'd10) rd_key = mem[rd_idx];
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key vectors.
// Store read-back checks are compiled in with AES_KEY_STORE_EN.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int total;
  int bad;

  localparam logic [127:0] K_F   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_F1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_F2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K_F10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_Z   = 128'h0;
  localparam logic [127:0] K_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .ready    (ready),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk       (rk),
    .done     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 128'(ready), 128'd1);
    check({tag, ".valid"}, 128'(rk_valid), 128'd0);
    check({tag, ".done"}, 128'(done), 128'd0);
  endtask

  // Called in the cycle rk_idx=0 is expected; returns in the cycle after idx 10.
  task automatic expect_stream(
    input string        tag,
    input logic [127:0] k0,
    input logic [127:0] k1,
    input logic [127:0] k2,
    input logic         has_k2,
    input logic [127:0] k10
  );
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("%s.valid%0d", tag, i), 128'(rk_valid), 128'd1);
      check($sformatf("%s.idx%0d", tag, i), 128'(rk_idx), 128'(i));
      check($sformatf("%s.ready%0d", tag, i), 128'(ready), 128'd0);
      check($sformatf("%s.done%0d", tag, i), 128'(done),
            128'(i == 10));
      if (i == 0)  check({tag, ".rk0"}, rk, k0);
      if (i == 1)  check({tag, ".rk1"}, rk, k1);
      if (i == 2 && has_k2) check({tag, ".rk2"}, rk, k2);
      if (i == 10) check({tag, ".rk10"}, rk, k10);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
`ifdef AES_KEY_STORE_EN
    rd_idx = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_idle("rst");
    check("rst.idx", 128'(rk_idx), 128'd0);
    check("rst.rk", rk, 128'd0);

    // FIPS-197 key, single-cycle start
    start = 1'b1;
    key   = K_F;
    tick();
    start = 1'b0;
    key   = '0;
    expect_stream("fips", K_F, K_F1, K_F2, 1'b1, K_F10);
    check_idle("fips.end");
    check("fips.hold_idx", 128'(rk_idx), 128'd10);
    check("fips.hold_rk", rk, K_F10);

`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd10;
    #1 check("store.rd10", rd_key, K_F10);
    rd_idx = 4'd0;
    #1 check("store.rd0", rd_key, K_F);
    rd_idx = 4'd1;
    #1 check("store.rd1", rd_key, K_F1);
    rd_idx = 4'd15;
    #1 check("store.rd15", rd_key, 128'd0);
    rd_idx = 4'd0;
`endif

    // All-zero key
    tick();
    start = 1'b1;
    key   = K_Z;
    tick();
    start = 1'b0;
    expect_stream("zero", K_Z, K_Z1, '0, 1'b0, K_Z10);
    check_idle("zero.end");

    // start held high; key changes during expansion are ignored
    start = 1'b1;
    key   = K_F;
    tick();
    key = {128{1'b1}};
    expect_stream("b2b1", K_F, K_F1, K_F2, 1'b1, K_F10);
    check("b2b1.ready", 128'(ready), 128'd1);
    key = K_Z;
    tick();
    start = 1'b0;
    expect_stream("b2b2", K_Z, K_Z1, '0, 1'b0, K_Z10);
    check_idle("b2b2.end");

    // Reset while rk_idx=5
    start = 1'b1;
    key   = K_F;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid.idx5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid.rst");
    check("mid.idx", 128'(rk_idx), 128'd0);
    check("mid.rk", rk, 128'd0);
`ifdef AES_KEY_STORE_EN
    check("mid.store", rd_key, 128'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mid.novalid%0d", i), 128'(rk_valid), 128'd0);
      tick();
    end
    start = 1'b1;
    key   = K_F;
    tick();
    start = 1'b0;
    expect_stream("mid.fips", K_F, K_F1, K_F2, 1'b1, K_F10);
    check_idle("mid.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
